// File: rtl/sd_1011_det_if.sv
// ---------------------------------------------------------------------------
// sd_1011_det_if
//   Serial-bit bundle between a bit source and the 1011 sequence detector.
//
//   Signals:
//     signal     serial data bit, driven by the source (master)
//     out        Mealy detect flag, driven by the detector (slave)
//     match_cnt  saturating match count, driven by the detector
//                (present only when SD_1011_MATCH_CNT_EN is defined)
//
//   Modports:
//     master  bit source / observer of the detect flag
//     slave   the detector itself
//
//   Parameter:
//     CNT_W   width of match_cnt; must match the detector's CNT_W.
// ---------------------------------------------------------------------------
interface sd_1011_det_if #(
   parameter int CNT_W = 8
);

   logic signal;
   logic out;
`ifdef SD_1011_MATCH_CNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   modport master (
      output signal,
      input  out
`ifdef SD_1011_MATCH_CNT_EN
      , input match_cnt
`endif
   );

   modport slave (
      input  signal,
      output out
`ifdef SD_1011_MATCH_CNT_EN
      , output match_cnt
`endif
   );

endinterface

// File: rtl/sd_1011_det.sv
// ---------------------------------------------------------------------------
// sd_1011_det
//   Overlapping Mealy detector for the serial pattern 1-0-1-1. One bit is
//   consumed on every rising clk edge; out is asserted combinationally in
//   the cycle the final '1' of a match is present on signal.
//
//   Ports:
//     clk   system clock, rising-edge active
//     rst   asynchronous reset, active low (0 = reset asserted)
//     bus   sd_1011_det_if.slave
//             bus.signal     serial input bit
//             bus.out        detect flag = (state == S3) && signal && rst
//             bus.match_cnt  saturating match counter (optional)
//
//   Parameter:
//     CNT_W  width of match_cnt (>= 1); only meaningful with the counter.
//
//   Optional feature:
//     SD_1011_MATCH_CNT_EN  when defined, adds bus.match_cnt which counts
//                           clock edges with out = 1, saturating at
//                           2^CNT_W - 1, cleared asynchronously by rst.
// ---------------------------------------------------------------------------
module sd_1011_det #(
   parameter int CNT_W = 8
) (
   input logic          clk,
   input logic          rst,
   sd_1011_det_if.slave bus
);

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("sd_1011_det: CNT_W must be >= 1");
   end

   // Prefix-tracking states
   localparam logic [1:0] S0 = 2'b00;  // no useful prefix
   localparam logic [1:0] S1 = 2'b01;  // "1" seen
   localparam logic [1:0] S2 = 2'b10;  // "10" seen
   localparam logic [1:0] S3 = 2'b11;  // "101" seen

   logic [1:0] state;
   logic [1:0] next_state;
   logic       hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S0;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S0:      next_state = bus.signal ? S1 : S0;
         S1:      next_state = bus.signal ? S1 : S2;
         S2:      next_state = bus.signal ? S3 : S0;
         // On a 0 the "10" suffix survives; on a 1 the trailing bit is a
         // fresh "1" prefix, which gives the overlapping behaviour.
         S3:      next_state = bus.signal ? S1 : S2;
         default: next_state = S0;
      endcase
   end

   assign hit = (state == S3) && bus.signal;

   // rst is folded in so the flag is a hard 0 during reset even if the
   // serial input is unknown.
   assign bus.out = hit && rst;

`ifdef SD_1011_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (hit && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.match_cnt = cnt;
`endif

endmodule

// File: tb/tb_sd_1011_det.sv
module tb_sd_1011_det;

   localparam int CNT_W = 2;

   logic clk;
   logic rst;

   sd_1011_det_if #(.CNT_W(CNT_W)) bus ();

   sd_1011_det #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // scoreboard of expected out values, pushed at drive time
   logic       exp_q[$];
   // reference model: last three bits since reset, and match count
   logic [2:0] hist;
   int unsigned mcnt;
   int unsigned dets;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist = 3'b000;
      mcnt = 0;
   endtask

   // Apply one bit for one cycle; check out during the low phase and the
   // counter just after the sampling edge.
   task automatic drive(input logic b, input string tag);
      logic e;
      logic o;
      @(negedge clk);
      bus.signal = b;
      exp_q.push_back((hist == 3'b101) && b);
      #1;
      o = bus.out;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {7'd0, o}, {7'd0, e});
         if (e && mcnt < (1 << CNT_W) - 1) mcnt++;
      end
      if (o === 1'b1) dets++;
      hist = {hist[1:0], b};
      @(posedge clk);
      #1;
`ifdef SD_1011_MATCH_CNT_EN
      chk({tag, "_cnt"}, 8'(bus.match_cnt), 8'(mcnt));
`endif
   endtask

   task automatic drive_seq(input logic [15:0] bits, input int unsigned n, input string tag);
      for (int i = int'(n) - 1; i >= 0; i--) drive(bits[i], tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      bus.signal = 1'bx;
      model_reset();

      // reset held for 2 cycles with X then 1 on the input
      @(negedge clk);
      #1;
      chk("rst_x_c0", {7'd0, bus.out}, 8'd0);
      @(posedge clk);
      #1;
      chk("rst_x_c1", {7'd0, bus.out}, 8'd0);
`ifdef SD_1011_MATCH_CNT_EN
      chk("rst_cnt", 8'(bus.match_cnt), 8'd0);
`endif
      @(negedge clk);
      bus.signal = 1'b1;
      #1;
      chk("rst_one", {7'd0, bus.out}, 8'd0);
      @(negedge clk);
      rst = 1'b1;

      // overlap via S3 -1-> S1 -0-> S2 -1-> S3
      dets = 0;
      drive_seq(16'b01011011, 8, "seqA");
      chk("seqA_dets", 8'(dets), 8'd2);

      // S3 -0-> S2
      dets = 0;
      drive_seq(16'b101011, 6, "seqB");
      chk("seqB_dets", 8'(dets), 8'd1);

      // S1 self-loop and S2 -0-> S0
      dets = 0;
      drive_seq(16'b111001011, 9, "seqC");
      chk("seqC_dets", 8'(dets), 8'd1);

      // 1011 followed by 011
      dets = 0;
      drive_seq(16'b1011011, 7, "seqOv");
      chk("seqOv_dets", 8'(dets), 8'd2);

      // reset pulse mid-cycle with state at S3 discards the prefix
      drive_seq(16'b101, 3, "seqD");
      @(negedge clk);
      bus.signal = 1'b1;
      rst = 1'b0;
      #1;
      chk("mid_rst_low", {7'd0, bus.out}, 8'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_rel", {7'd0, bus.out}, 8'd0);
`ifdef SD_1011_MATCH_CNT_EN
      chk("mid_rst_cnt", 8'(bus.match_cnt), 8'd0);
`endif
      model_reset();
      dets = 0;
      drive(1'b1, "postD");
      drive_seq(16'b1011, 4, "seqE");
      chk("seqE_dets", 8'(dets), 8'd1);

      // counter saturation: 1011 x5 from a clean reset
      @(negedge clk);
      rst = 1'b0;
      bus.signal = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      dets = 0;
      for (int r = 0; r < 5; r++) drive_seq(16'b1011, 4, "sat");
      chk("sat_dets", 8'(dets), 8'd5);
`ifdef SD_1011_MATCH_CNT_EN
      chk("sat_cnt_final", 8'(bus.match_cnt), 8'd3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("sat_cnt_clr", 8'(bus.match_cnt), 8'd0);
      rst = 1'b1;
`endif

      chk("sb_drained", 8'(exp_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sd_1011_det.md
Name: sd_1011_det

Overview:
- Overlapping Mealy sequence detector for the serial bit pattern 1-0-1-1 on a single-bit input stream.
- Samples `signal` on each rising edge of `clk`.
- Asserts `out` combinationally in the same cycle the final '1' of a match is present at the input.
- Sits at a serial-input boundary as a pattern-flag generator for downstream control logic.

Parameters:
- CNT_W, 8, width of the optional match counter. Used only when MATCH_CNT_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- signal  input  1  serial data bit, sampled on the rising edge of clk.
- out  output  1  Mealy detect flag; 1 while the current state is S3 and signal = 1.
- match_cnt  output  CNT_W  saturating match count; present only with MATCH_CNT_EN.

Behaviour:
- One clock domain and one asynchronous active-low reset, as already decided.
- Reset (rst = 0):
  - State goes to S0 immediately, without waiting for a clock edge.
  - out is forced to 0 for as long as rst = 0, even if signal is X.
  - match_cnt, when present, is cleared to 0.
- Reset release: the first sampling edge is the first rising clk edge with rst = 1.
- States (2-bit encoding; exact codes are free):
  - S0 = no useful prefix.
  - S1 = "1" seen.
  - S2 = "10" seen.
  - S3 = "101" seen.
- Transitions on the rising clk edge, written as input -> next state:
  - S0: 0 -> S0, 1 -> S1.
  - S1: 0 -> S2, 1 -> S1.
  - S2: 0 -> S0, 1 -> S3.
  - S3: 0 -> S2 (the "10" suffix is kept), 1 -> S1 (overlap: the trailing '1' starts a new prefix).
- Output:
  - out = (state == S3) && signal && rst. It is purely combinational from the registered state and the live input.
  - Latency: zero. out rises in the same cycle the 4th bit is applied.
  - out falls when signal changes or when the edge moves the state out of S3.
  - out can glitch with signal; downstream logic samples it on the clk edge.
- Overlap rules:
  - Input 1011011 yields two detections (bits 4 and 7).
  - Input 1011 followed by 011 also counts the second match.
- Unknown signal (X) after reset: no requirement; the bench drives known values after reset release.
- Reset mid-sequence discards all partial progress; a full 1011 is required after release.
- No handshake and no back-pressure; one bit is consumed every cycle.

Optional Feature:
- Macro: SD_1011_MATCH_CNT_EN.
- Defined:
  - Adds output match_cnt[CNT_W-1:0].
  - Increments by 1 on each rising clk edge where out = 1 (i.e. state == S3 and signal = 1).
  - Saturates at 2^CNT_W - 1; no wrap.
  - Cleared asynchronously by rst = 0.
- Undefined: port and logic are absent; the detector behaves identically otherwise.

Test Plan:
- Hold rst = 0 for 2 cycles with signal = X/1 -> out = 0 and state S0 throughout; after release, the first 0 keeps out = 0.
- After reset, drive 0,1,0,1,1,0,1,1, one bit per cycle -> out = 1 only during the 5th and 8th bits; exactly 2 detections (overlap via S3 -1-> S1 -0-> S2 -1-> S3).
- Drive 1,0,1,0,1,1 -> out = 1 only on the 6th bit (exercises S3 -0-> S2).
- Drive 1,1,1,0,0,1,0,1,1 -> out = 1 only on the last bit (exercises S1 self-loop and S2 -0-> S0).
- Drive 1,0,1, then pulse rst low mid-cycle, then 1 -> out stays 0; a fresh 1,0,1,1 then gives out = 1 on its 4th bit.
- With SD_1011_MATCH_CNT_EN and CNT_W = 2: drive 1011 repeated 5 times -> match_cnt goes 1,2,3,3,3; reset clears it to 0.
